// File: rtl/rollcall_pkg.sv
// Shared types and sizes for the roll-call framer and its frame buffer.
package rollcall_pkg;
   localparam int SYM_W     = 2;
   localparam int NUM_SLOTS = 4;
   localparam int IDX_W     = 2;

   typedef enum logic {FILL, FULL} state_t;

   typedef struct packed {
      logic [NUM_SLOTS-1:0][SYM_W-1:0] s;
      logic [SYM_W-1:0]                pat;
      logic                            mode;
   } frame_t;
endpackage

// File: rtl/rollcall_framer_if.sv
// Symbol-in / frame-out handshake bundle between the framer, its feeder and the matcher.
interface rollcall_framer_if #(
   parameter int SYM_W = rollcall_pkg::SYM_W,
   parameter int ID_W  = 4
);
   logic             in_valid;
   logic             in_ready;
   logic [SYM_W-1:0] in_sym;
   logic [SYM_W-1:0] in_pat;
   logic             in_mode;
   logic             flush;
   logic             out_valid;
   logic             out_ready;
   logic [SYM_W-1:0] s0, s1, s2, s3;
   logic [SYM_W-1:0] pat;
   logic             mode;
   logic [ID_W-1:0]  frame_id;
   logic [2:0]       fill_lvl;

   modport master (
      output in_valid, in_sym, in_pat, in_mode, flush, out_ready,
      input  in_ready, out_valid, s0, s1, s2, s3, pat, mode, frame_id, fill_lvl
   );

   modport slave (
      input  in_valid, in_sym, in_pat, in_mode, flush, out_ready,
      output in_ready, out_valid, s0, s1, s2, s3, pat, mode, frame_id, fill_lvl
   );
endinterface

// File: rtl/rollcall_frame_buf.sv
// Four-slot write-indexed frame register; PAT/MODE captured on the slot-0 write.
module rollcall_frame_buf
   import rollcall_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr,
   input  logic             wr_en,
   input  logic [SYM_W-1:0] sym,
   input  logic [SYM_W-1:0] pat,
   input  logic             mode,
   output frame_t           frame,
   output logic [IDX_W-1:0] idx,
   output logic             done
);
   frame_t           frame_q;
   logic [IDX_W-1:0] idx_q;
   logic             wr;

   assign wr = wr_en & ~clr;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         frame_q <= '0;
         idx_q   <= '0;
      end else if (clr) begin
         idx_q <= '0;
      end else if (wr_en) begin
         frame_q.s[idx_q] <= sym;
         if (idx_q == '0) begin
            frame_q.pat  <= pat;
            frame_q.mode <= mode;
         end
         idx_q <= idx_q + IDX_W'(1);
      end
   end

   // Write-through view so the completing symbol is visible on the edge it lands.
   always_comb begin
      frame = frame_q;
      if (wr) begin
         frame.s[idx_q] = sym;
         if (idx_q == '0) begin
            frame.pat  = pat;
            frame.mode = mode;
         end
      end
   end

   assign idx  = idx_q;
   assign done = wr & (idx_q == IDX_W'(NUM_SLOTS - 1));
endmodule

// File: rtl/rollcall_framer.sv
// Packs 2-bit symbols into 4-symbol frames for the roll-call matcher.
// Optional ROLLCALL_FRAMER_DBUF_EN: second frame register so filling overlaps output.
module rollcall_framer
   import rollcall_pkg::*;
#(
   parameter int ID_W = 4
)
(
   input logic              clk,
   input logic              rst_n,
   rollcall_framer_if.slave bus
);
   state_t           state, state_nxt;
   logic             accept, take, done;
   logic             in_ready, out_valid;
   logic [IDX_W-1:0] fill_idx;
   logic [2:0]       fill_lvl;
   frame_t           out_frame;
   logic [ID_W-1:0]  frame_id;

   assign accept = bus.in_valid & in_ready;
   assign take   = out_valid & bus.out_ready;

   always_ff @(posedge clk) begin
      if (!rst_n) state <= FILL;
      else        state <= state_nxt;
   end

   always_ff @(posedge clk) begin
      if (!rst_n)    frame_id <= '0;
      else if (take) frame_id <= frame_id + ID_W'(1);
   end

`ifndef ROLLCALL_FRAMER_DBUF_EN
   frame_t fill_frame;
   frame_t out_q;

   rollcall_frame_buf u_buf (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (bus.flush),
      .wr_en (accept),
      .sym   (bus.in_sym),
      .pat   (bus.in_pat),
      .mode  (bus.in_mode),
      .frame (fill_frame),
      .idx   (fill_idx),
      .done  (done)
   );

   // FULL means the output register holds the frame awaiting the matcher.
   always_comb begin
      state_nxt = state;
      case (state)
         FILL:    if (done) state_nxt = FULL;
         FULL:    if (take) state_nxt = FILL;
         default: state_nxt = FILL;
      endcase
   end

   always_comb begin
      in_ready  = (state == FILL) & ~bus.flush;
      out_valid = (state == FULL);
      fill_lvl  = (state == FULL) ? 3'd4 : {1'b0, fill_idx};
   end

   always_ff @(posedge clk) begin
      if (!rst_n)    out_q <= '0;
      else if (done) out_q <= fill_frame;
   end

   assign out_frame = out_q;
`else
   frame_t           frame0, frame1;
   logic [IDX_W-1:0] idx0, idx1;
   logic             done0, done1;
   logic             sel;
   logic             out_valid_q;
   logic             handoff;

   // sel names the buffer on the output; the other one is always the fill buffer.
   rollcall_frame_buf u_buf0 (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (bus.flush & sel),
      .wr_en (accept & sel),
      .sym   (bus.in_sym),
      .pat   (bus.in_pat),
      .mode  (bus.in_mode),
      .frame (frame0),
      .idx   (idx0),
      .done  (done0)
   );

   rollcall_frame_buf u_buf1 (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (bus.flush & ~sel),
      .wr_en (accept & ~sel),
      .sym   (bus.in_sym),
      .pat   (bus.in_pat),
      .mode  (bus.in_mode),
      .frame (frame1),
      .idx   (idx1),
      .done  (done1)
   );

   assign fill_idx  = sel ? idx0 : idx1;
   assign done      = sel ? done0 : done1;
   assign out_frame = sel ? frame1 : frame0;

   // FULL means the fill buffer holds a complete frame blocked behind the output.
   always_comb begin
      state_nxt = state;
      case (state)
         FILL:    if (done & out_valid_q & ~bus.out_ready) state_nxt = FULL;
         FULL:    if (bus.flush | bus.out_ready) state_nxt = FILL;
         default: state_nxt = FILL;
      endcase
   end

   always_comb begin
      in_ready  = (state == FILL) & ~bus.flush;
      out_valid = out_valid_q;
      fill_lvl  = (state == FULL) ? 3'd4 : {1'b0, fill_idx};
   end

   assign handoff = ((state == FILL) & done & (~out_valid_q | bus.out_ready)) |
                    ((state == FULL) & ~bus.flush & bus.out_ready);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sel         <= 1'b0;
         out_valid_q <= 1'b0;
      end else if (handoff) begin
         sel         <= ~sel;
         out_valid_q <= 1'b1;
      end else if (take) begin
         out_valid_q <= 1'b0;
      end
   end
`endif

   assign bus.in_ready  = in_ready;
   assign bus.out_valid = out_valid;
   assign bus.s0        = out_frame.s[0];
   assign bus.s1        = out_frame.s[1];
   assign bus.s2        = out_frame.s[2];
   assign bus.s3        = out_frame.s[3];
   assign bus.pat       = out_frame.pat;
   assign bus.mode      = out_frame.mode;
   assign bus.frame_id  = frame_id;
   assign bus.fill_lvl  = fill_lvl;
endmodule
